md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, which sets the operand and HI/LO width in bits.
REQ-002 SHALL provide parameter MULT_CYCLES, default 5, which sets the busy length of a multiply (legal range 1..31).
REQ-003 SHALL provide parameter DIV_CYCLES, default 10, which sets the busy length of a divide (legal range 1..31).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset=0 resets).
REQ-006 SHALL have port start, input, 1 bit: request strobe, sampled on the rising edge.
REQ-007 SHALL have port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: operands (a is dividend or rs, b is divisor or rt).
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse on completion.
REQ-011 SHALL have ports hi and lo, output, WIDTH bits each: the architectural HI/LO registers, driven directly from flops.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 SHALL, in IDLE with start=1 and op in {0,1,2,3} (or {6,7} when enabled), latch a, b and op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-014 SHALL hold busy=1 for exactly N cycles after the accepting edge, where N is the selected cycle count.
REQ-015 SHALL, on the edge that ends RUN, write the result to hi/lo, return to IDLE and deassert busy; done SHALL be 1 for the following cycle only.
REQ-016 SHALL keep hi/lo at their previous values throughout RUN.
REQ-017 SHALL ignore start entirely while busy=1: no latch, no restart, no hi/lo change.
REQ-018 SHALL, for MTHI/MTLO with busy=0, write a into hi/lo on the same edge, with no busy and no done.
REQ-019 SHALL, for MULT, produce the signed 2*WIDTH product, with {hi,lo} = a*b; MULTU SHALL do the same unsigned.
REQ-020 SHALL, for DIV, set lo to the signed quotient truncated toward zero and hi to the remainder carrying the dividend's sign; DIVU SHALL do the same unsigned.
REQ-021 SHALL, on divide by zero (b=0), still run DIV_CYCLES and pulse done, but leave hi/lo unchanged.
REQ-022 SHALL, for signed DIV of most-negative by -1, give lo = most-negative and hi = 0.
REQ-023 SHALL treat op 6/7 as a no-op (no busy, no change) when the macro in REQ-027 is undefined.

Reset
REQ-024 SHALL, while reset=0 (asynchronously), force hi=0, lo=0, busy=0, done=0, FSM=IDLE and counter=0.
REQ-025 SHALL, on reset during RUN, abort the operation with no hi/lo write and no done pulse.
REQ-026 SHALL accept a new start on the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL, with MD_MADD_EN defined, support op 6 MADD ({hi,lo} += signed a*b) and op 7 MSUB ({hi,lo} -= signed a*b), both with MULT_CYCLES latency and 2*WIDTH wrap-around; without the macro, behave per REQ-023 and synthesise no accumulate adder.

Verification
REQ-028 SHALL cover signed multiply: MULT a=0xFFFFFFFE, b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse 1 cycle.
REQ-029 SHALL cover signed divide: DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU of the same operands -> lo=0x7FFFFFFC, hi=1.
REQ-030 SHALL cover divide by zero: MTHI 0x1234 and MTLO 0x5678, then DIV b=0 -> busy 10 cycles, done pulses, hi=0x1234, lo=0x5678.
REQ-031 SHALL cover start while busy: MULT 2*3, then on cycle 2 issue MTLO 0xDEAD with start=1 -> ignored; final lo=6, hi=0.
REQ-032 SHALL cover reset mid-operation: reset=0 on cycle 3 of DIVU -> hi=lo=0, busy=0, no done; a MULTU 0xFFFFFFFF*0xFFFFFFFF issued after release -> hi=0xFFFFFFFE, lo=1.
REQ-033 SHALL cover accumulate, with MD_MADD_EN defined: MTHI 0, MTLO 0xFFFFFFFF, then MADD 1*1 -> hi=1, lo=0; without the macro -> hi/lo unchanged and busy stays 0.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Define MD_MADD_EN to enable MADD/MSUB (op 6/7) accumulate ops.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [4:0] MC = 5'(MULT_CYCLES);
  localparam logic [4:0] DC = 5'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_mul;
  logic             is_div;
  logic signed [W2-1:0]    a_sx, b_sx, prod_s;
  logic [W2-1:0]           prod_u;
  logic signed [WIDTH-1:0] a_sw, b_sw, quo_s, rem_s;
  logic [WIDTH-1:0]        quo_u, rem_u;
  logic                    wr_en;
  logic [WIDTH-1:0]        res_hi, res_lo;
`ifdef MD_MADD_EN
  logic [W2-1:0]           acc_add, acc_sub;
`endif

  // Decode which requests start a multi-cycle operation.
  always_comb begin
    is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MD_MADD_EN
    is_mul = (op == OP_MULT) || (op == OP_MULTU) ||
             (op == OP_MADD) || (op == OP_MSUB);
`else
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
  end

  // Arithmetic datapath on the latched operands.
  always_comb begin
    a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_s = a_sx * b_sx;
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    a_sw   = a_q;
    b_sw   = b_q;
    quo_s  = a_sw / b_sw;
    rem_s  = a_sw % b_sw;
    quo_u  = a_q / b_q;
    rem_u  = a_q % b_q;
`ifdef MD_MADD_EN
    acc_add = {hi_q, lo_q} + prod_s;
    acc_sub = {hi_q, lo_q} - prod_s;
`endif
  end

  // Select the HI/LO result written when RUN completes.
  always_comb begin
    wr_en  = 1'b1;
    res_hi = hi_q;
    res_lo = lo_q;
    unique case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (b_q == '0) begin
          wr_en = 1'b0;
        end else if (a_q == MIN_NEG && b_q == ALL_ONE) begin
          res_lo = MIN_NEG;
          res_hi = '0;
        end else begin
          res_lo = quo_s;
          res_hi = rem_s;
        end
      end
      OP_DIVU: begin
        if (b_q == '0) begin
          wr_en = 1'b0;
        end else begin
          res_lo = quo_u;
          res_hi = rem_u;
        end
      end
`ifdef MD_MADD_EN
      OP_MADD: {res_hi, res_lo} = acc_add;
      OP_MSUB: {res_hi, res_lo} = acc_sub;
`endif
      default: wr_en = 1'b0;
    endcase
  end

  // FSM next state: accept in IDLE, count down in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul, is_div: begin
              state_d = RUN;
              busy_d  = 1'b1;
              cnt_d   = is_mul ? MC : DC;
              op_d    = op;
              a_d     = a;
              b_d     = b;
            end
            op == OP_MTHI: hi_d = a;
            op == OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q <= 5'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          if (wr_en) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed table, corner sequences and randomized
// checks of md_unit against a longint reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] m_hl = '0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int lat(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return 5;
      3'd2, 3'd3: return 10;
`ifdef MD_MADD_EN
      3'd6, 3'd7: return 5;
`endif
      default: return 0;
    endcase
  endfunction

  // Reference: new {hi,lo} from the architectural rules.
  function automatic logic [63:0] model(input logic [2:0] o,
      input logic [31:0] x, input logic [31:0] y,
      input logic [63:0] hl);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) return hl;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (y == 0) return hl;
        uq = x / y;
        ur = x % y;
        return {ur, uq};
      end
      3'd4: return {x, hl[31:0]};
      3'd5: return {hl[63:32], x};
`ifdef MD_MADD_EN
      3'd6: return hl + 64'(sa * sb);
      3'd7: return hl - 64'(sa * sb);
`endif
      default: return hl;
    endcase
  endfunction

  // Issue one op and check busy window, done pulse and result.
  task automatic issue(input logic [2:0] o, input logic [31:0] x,
      input logic [31:0] y, input logic [63:0] exp,
      input bit spam, input string nm);
    int n;
    n = lat(o);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      check({nm, "_busy"}, 64'(busy), 64'd0);
      check({nm, "_done"}, 64'(done), 64'd0);
      check({nm, "_hilo"}, {hi, lo}, exp);
    end else begin
      for (int k = 0; k < n; k++) begin
        check({nm, "_busy"}, 64'(busy), 64'd1);
        if (done) check({nm, "_early_done"}, 64'(done), 64'd0);
        if (k == n - 1) check({nm, "_hold"}, {hi, lo}, m_hl);
        if (spam) begin
          start = 1'($urandom);
          op = 3'($urandom);
          a = $urandom;
          b = $urandom;
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
      check({nm, "_end_busy"}, 64'(busy), 64'd0);
      check({nm, "_done"}, 64'(done), 64'd1);
      check({nm, "_hilo"}, {hi, lo}, exp);
      @(posedge clk); #1;
      check({nm, "_done_clr"}, 64'(done), 64'd0);
    end
    m_hl = exp;
  endtask

  vec_t vt[10];
  logic [31:0] pick[5];

  initial begin
    vt[0] = '{32'h0, 32'h0, 3'd0, 32'hFFFFFFFE, 32'd3,
              32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[1] = '{32'h0, 32'h0, 3'd2, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[2] = '{32'h0, 32'h0, 3'd3, 32'hFFFFFFF9, 32'd2,
              32'h1, 32'h7FFFFFFC};
    vt[3] = '{32'h1234, 32'h5678, 3'd2, 32'd99, 32'd0,
              32'h1234, 32'h5678};
    vt[4] = '{32'h1, 32'h1, 3'd2, 32'h80000000, 32'hFFFFFFFF,
              32'h0, 32'h80000000};
    vt[5] = '{32'h0, 32'h0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h1};
    vt[6] = '{32'h0, 32'h0, 3'd0, 32'h80000000, 32'h80000000,
              32'h40000000, 32'h0};
    vt[7] = '{32'h0, 32'h0, 3'd2, 32'd7, 32'hFFFFFFFE,
              32'h1, 32'hFFFFFFFD};
    vt[8] = '{32'h0, 32'hFFFFFFFF, 3'd6, 32'd1, 32'd1,
              32'h0, 32'hFFFFFFFF};
    vt[9] = '{32'h0, 32'h0, 3'd7, 32'd2, 32'd3,
              32'h0, 32'h0};
`ifdef MD_MADD_EN
    vt[8].exp_hi = 32'h1;
    vt[8].exp_lo = 32'h0;
    vt[9].exp_hi = 32'hFFFFFFFF;
    vt[9].exp_lo = 32'hFFFFFFFA;
`endif

    #2 reset = 1'b0;
    #2;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    m_hl = '0;

    for (int i = 0; i < 10; i++) begin
      issue(3'd4, vt[i].pre_hi, 32'd0,
            {vt[i].pre_hi, m_hl[31:0]}, 1'b0, "pre_hi");
      issue(3'd5, vt[i].pre_lo, 32'd0,
            {vt[i].pre_hi, vt[i].pre_lo}, 1'b0, "pre_lo");
      issue(vt[i].op, vt[i].a, vt[i].b,
            {vt[i].exp_hi, vt[i].exp_lo}, 1'b0,
            $sformatf("vec%0d", i));
    end

    // Start while busy: MTLO on cycle 2 must be ignored.
    issue(3'd4, 32'd0, 32'd0, {32'd0, m_hl[31:0]}, 1'b0, "sb_hi");
    issue(3'd5, 32'd0, 32'd0, 64'd0, 1'b0, "sb_lo");
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; a = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0;
    check("sb_busy", 64'(busy), 64'd1);
    check("sb_hold", {hi, lo}, 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("sb_done", 64'(done), 64'd1);
    check("sb_hilo", {hi, lo}, 64'd6);
    @(posedge clk); #1;
    m_hl = 64'd6;

    // Reset during DIVU, then MULTU on the first edge after release.
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("mrst_hilo", {hi, lo}, 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("mrst_hold_done", 64'(done), 64'd0);
    reset = 1'b1;
    m_hl = '0;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
          {32'hFFFFFFFE, 32'h1}, 1'b0, "post_rst_multu");

    // Randomized ops with junk start traffic while busy.
    pick[0] = 32'd0;
    pick[1] = 32'd1;
    pick[2] = 32'hFFFFFFFF;
    pick[3] = 32'h80000000;
    for (int i = 0; i < 300; i++) begin
      logic [2:0] o;
      logic [31:0] x, y;
      pick[4] = $urandom;
      o = 3'($urandom);
      x = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)]
                                      : $urandom;
      y = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)]
                                      : $urandom;
      issue(o, x, y, model(o, x, y, m_hl), 1'b1,
            $sformatf("rnd%0d_op%0d", i, o));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
